// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - mode encodings and button indices shared by the mode sequencer
package mode_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_UART  = 2'd1,
    MODE_RST   = 2'd2,
    MODE_PAUSE = 2'd3
  } mode_t;

  localparam int BTN_PAUSE = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_RST   = 2;
  localparam int BTN_UART  = 3;
  localparam int BTN_RUN   = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise and debounce one raw button, emit a one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The flip lands on the edge where the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - button-driven mode FSM granting the CPU or the UART loader
// SINGLE_STEP_EN adds the PAUSE mode with b0 pause/resume and b1 single-step.
module mode_controller
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CPU_RST_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] buttons,
  input  logic       uart_busy,
  output logic [1:0] mode,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic       uart_en,
  output logic       mode_changed
);

  localparam int RCW = $clog2(CPU_RST_CYCLES + 1);

  logic [4:0] press;
  logic [4:0] btn_stable_unused;

`ifdef SINGLE_STEP_EN
  localparam int FIRST_BTN = BTN_PAUSE;
`else
  localparam int FIRST_BTN = BTN_RST;
  logic btn_raw_unused;
  assign press[1:0]             = '0;
  assign btn_stable_unused[1:0] = '0;
  assign btn_raw_unused         = ^buttons[1:0];
`endif

  for (genvar i = FIRST_BTN; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (buttons[i]),
      .stable (btn_stable_unused[i]),
      .press  (press[i])
    );
  end

  mode_t          mode_q, mode_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           pending_q, pending_d;
  logic           step_q, step_d;
  logic           mode_changed_q, mode_changed_d;
  logic           to_rst;

  // if/else chains encode the press priority b2 > b3 > b4 > b0 > b1.
  always_comb begin
    mode_d    = mode_q;
    rst_cnt_d = rst_cnt_q;
    pending_d = pending_q;
    step_d    = 1'b0;
    to_rst    = 1'b0;
    case (mode_q)
      MODE_RST: begin
        if (rst_cnt_q <= RCW'(1)) mode_d = MODE_RUN;
        else                      rst_cnt_d = rst_cnt_q - 1'b1;
      end
      MODE_RUN: begin
        if (press[BTN_RST])       to_rst = 1'b1;
        else if (press[BTN_UART]) mode_d = MODE_UART;
`ifdef SINGLE_STEP_EN
        else if (press[BTN_RUN])   mode_d = MODE_RUN;
        else if (press[BTN_PAUSE]) mode_d = MODE_PAUSE;
`endif
      end
      MODE_UART: begin
        // Leaving UART always goes through RST so the new program boots cleanly.
        if (press[BTN_RST])                to_rst = 1'b1;
        else if (pending_q && !uart_busy)  to_rst = 1'b1;
        else if (press[BTN_RUN])           pending_d = 1'b1;
      end
`ifdef SINGLE_STEP_EN
      MODE_PAUSE: begin
        if (press[BTN_RST])                   to_rst = 1'b1;
        else if (press[BTN_UART])             mode_d = MODE_UART;
        else if (press[BTN_RUN])              mode_d = MODE_PAUSE;
        else if (press[BTN_PAUSE])            mode_d = MODE_RUN;
        else if (press[BTN_STEP] && !step_q)  step_d = 1'b1;
      end
`endif
      default: to_rst = 1'b1;
    endcase
    if (to_rst) begin
      mode_d    = MODE_RST;
      rst_cnt_d = RCW'(CPU_RST_CYCLES);
      pending_d = 1'b0;
    end
    mode_changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= MODE_RST;
      rst_cnt_q      <= RCW'(CPU_RST_CYCLES);
      pending_q      <= 1'b0;
      step_q         <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      rst_cnt_q      <= rst_cnt_d;
      pending_q      <= pending_d;
      step_q         <= step_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign mode         = mode_q;
  assign cpu_en       = (mode_q == MODE_RUN) || step_q;
  assign cpu_rst      = (mode_q == MODE_RST);
  assign uart_en      = (mode_q == MODE_UART);
  assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_mode_controller.sv
// tb/tb_mode_controller.sv - self-checking bench for mode_controller (vector table + mode scoreboard)
module tb_mode_controller;
  import mode_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] buttons;
  logic       uart_busy;
  logic [1:0] mode;
  logic       cpu_en, cpu_rst, uart_en, mode_changed;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] sb_e;

  typedef struct {
    string      name;
    logic [4:0] btn;
    int         hold;
    logic       busy;
    logic [1:0] exp_mode;
    int         n_push;
    logic [1:0] p0;
    logic [1:0] p1;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mode_controller dut (
    .clk          (clk),
    .rst          (rst),
    .buttons      (buttons),
    .uart_busy    (uart_busy),
    .mode         (mode),
    .cpu_en       (cpu_en),
    .cpu_rst      (cpu_rst),
    .uart_en      (uart_en),
    .mode_changed (mode_changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for_mode(input string name, input logic [1:0] m, input int max, output int n);
    n = 0;
    while (mode !== m && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, mode, m);
  endtask

  task automatic count_rst(input string name);
    int n = 0;
    while (cpu_rst === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 8);
    check({name, "_then_run"}, mode, MODE_RUN);
  endtask

  task automatic add_vec(input string name, input logic [4:0] btn, input int hold, input logic busy,
                         input logic [1:0] exp_mode, input int n_push, input logic [1:0] p0,
                         input logic [1:0] p1);
    vec_t v;
    v.name = name; v.btn = btn; v.hold = hold; v.busy = busy;
    v.exp_mode = exp_mode; v.n_push = n_push; v.p0 = p0; v.p1 = p1;
    vecs.push_back(v);
  endtask

  // Every mode_changed pulse must match the next predicted mode.
  always @(negedge clk) begin
    if (rst === 1'b0 && mode_changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: mode changed to %0d, no change expected", mode);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_mode", mode, sb_e);
        check("sb_cpu_rst", cpu_rst, sb_e == MODE_RST);
        check("sb_uart_en", uart_en, sb_e == MODE_UART);
        check("sb_cpu_en", cpu_en, sb_e == MODE_RUN);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    buttons = '0;
    uart_busy = 1'b0;

    add_vec("b3_glitch",    5'b01000, 10, 1'b0, MODE_RUN,  0, MODE_RUN,  MODE_RUN);
    add_vec("b4_in_run",    5'b10000, 30, 1'b0, MODE_RUN,  0, MODE_RUN,  MODE_RUN);
    add_vec("b2_hold15",    5'b00100, 15, 1'b0, MODE_RUN,  0, MODE_RUN,  MODE_RUN);
    add_vec("b2_hold16",    5'b00100, 16, 1'b0, MODE_RUN,  2, MODE_RST,  MODE_RUN);
    add_vec("b3_to_uart",   5'b01000, 30, 1'b0, MODE_UART, 1, MODE_UART, MODE_UART);
    add_vec("b3_in_uart",   5'b01000, 30, 1'b0, MODE_UART, 0, MODE_UART, MODE_UART);
    add_vec("b2_uart_busy", 5'b00100, 30, 1'b1, MODE_RUN,  2, MODE_RST,  MODE_RUN);
`ifndef SINGLE_STEP_EN
    add_vec("b0b1_ignored", 5'b00011, 30, 1'b0, MODE_RUN,  0, MODE_RUN,  MODE_RUN);
`endif

    cycles(3);
    check("reset_mode", mode, MODE_RST);
    check("reset_cpu_rst", cpu_rst, 1'b1);
    check("reset_cpu_en", cpu_en, 1'b0);
    check("reset_uart_en", uart_en, 1'b0);
    check("reset_mode_changed", mode_changed, 1'b0);
    exp_q.push_back(MODE_RUN);
    rst = 1'b0;
    count_rst("reset_release_len");
    check("run_cpu_en", cpu_en, 1'b1);

    foreach (vecs[i]) begin
      uart_busy = vecs[i].busy;
      if (vecs[i].n_push > 0) exp_q.push_back(vecs[i].p0);
      if (vecs[i].n_push > 1) exp_q.push_back(vecs[i].p1);
      buttons = vecs[i].btn;
      cycles(vecs[i].hold);
      buttons = '0;
      cycles(45);
      check({vecs[i].name, "_mode"}, mode, vecs[i].exp_mode);
      check({vecs[i].name, "_uart_en"}, uart_en, vecs[i].exp_mode == MODE_UART);
      check({vecs[i].name, "_cpu_en"}, cpu_en, vecs[i].exp_mode == MODE_RUN);
      uart_busy = 1'b0;
    end

    exp_q.push_back(MODE_UART);
    buttons = 5'b01000;
    wait_for_mode("b3_latency_mode", MODE_UART, 40, n);
    check("b3_latency_edges", n, 19);
    check("b3_latency_uart_en", uart_en, 1'b1);
    cycles(15);
    buttons = '0;
    cycles(25);

    uart_busy = 1'b1;
    buttons = 5'b10000;
    cycles(30);
    buttons = '0;
    cycles(25);
    check("busy_holds_uart", mode, MODE_UART);
    exp_q.push_back(MODE_RST);
    exp_q.push_back(MODE_RUN);
    uart_busy = 1'b0;
    @(negedge clk);
    check("exit_rst_next_cycle", mode, MODE_RST);
    count_rst("exit_rst_len");
    cycles(10);

    exp_q.push_back(MODE_RST);
    exp_q.push_back(MODE_RUN);
    buttons = 5'b01100;
    wait_for_mode("b2_beats_b3", MODE_RST, 40, n);
    count_rst("b2_b3_rst_len");
    buttons = '0;
    cycles(25);
    check("b2_b3_final", mode, MODE_RUN);

    exp_q.push_back(MODE_RST);
    buttons = 5'b00100;
    wait_for_mode("pre_rst_pulse", MODE_RST, 40, n);
    buttons = '0;
    cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mode_changed", mode_changed, 1'b0);
    check("mid_rst_cpu_rst", cpu_rst, 1'b1);
    exp_q.push_back(MODE_RUN);
    rst = 1'b0;
    count_rst("rst_restart_len");
    cycles(25);

`ifdef SINGLE_STEP_EN
    exp_q.push_back(MODE_PAUSE);
    buttons = 5'b00001;
    wait_for_mode("b0_to_pause", MODE_PAUSE, 40, n);
    check("pause_cpu_en", cpu_en, 1'b0);
    buttons = '0;
    cycles(25);
    buttons = 5'b00010;
    n = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) n++;
    end
    check("step_cpu_en_cycles", n, 1);
    buttons = '0;
    cycles(25);
    exp_q.push_back(MODE_RUN);
    buttons = 5'b00001;
    wait_for_mode("b0_to_run", MODE_RUN, 40, n);
    buttons = '0;
    cycles(25);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
